// File: rtl/dr_arb_pkg.sv
// Shared types and constants for the DR load arbiter.
// Optional round-robin arbitration is selected with DR_ARB_RR_EN.
package dr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  localparam int unsigned SRC_BUS  = 0;
  localparam int unsigned SRC_DM   = 1;
  localparam int unsigned SRC_INSM = 2;
  localparam int unsigned NUM_SRC  = 3;
  localparam int unsigned CNT_W    = 4;

  typedef logic [NUM_SRC-1:0] src_vec_t;
  typedef logic [1:0]         src_idx_t;

  function automatic src_idx_t onehot_to_idx(input src_vec_t v);
    if (v[SRC_DM])   return src_idx_t'(SRC_DM);
    if (v[SRC_INSM]) return src_idx_t'(SRC_INSM);
    return src_idx_t'(SRC_BUS);
  endfunction

  // Round-robin order bus -> DM -> InsM -> bus.
  function automatic src_idx_t next_src(input src_idx_t s);
    return (s == src_idx_t'(SRC_INSM)) ? src_idx_t'(SRC_BUS) : s + 2'd1;
  endfunction

endpackage

// File: rtl/dr_arb_pick.sv
// Combinational winner select: fixed InsM > DM > bus, or round-robin
// from ptr when DR_ARB_RR_EN is defined.
module dr_arb_pick
  import dr_arb_pkg::*;
(
`ifdef DR_ARB_RR_EN
  input  src_idx_t ptr,
`endif
  input  src_vec_t req,
  output src_vec_t gnt
);

`ifdef DR_ARB_RR_EN
  src_idx_t idx;
  logic     found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx = src_idx_t'((32'(ptr) + i) % NUM_SRC);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  always_comb begin
    gnt = '0;
    if (req[SRC_INSM])     gnt[SRC_INSM] = 1'b1;
    else if (req[SRC_DM])  gnt[SRC_DM]   = 1'b1;
    else if (req[SRC_BUS]) gnt[SRC_BUS]  = 1'b1;
  end
`endif

endmodule

// File: rtl/dr_load_arbiter.sv
// Sequencer/arbiter for the DR load paths (bus, DM, InsM).
// Define DR_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module dr_load_arbiter
  import dr_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MEM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_bus,
  input  logic                  req_dm,
  input  logic                  req_insm,
  input  logic [ADDR_WIDTH-1:0] dm_addr_in,
  input  logic [ADDR_WIDTH-1:0] insm_addr_in,
  output logic                  dm_rd,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic                  insm_rd,
  output logic [ADDR_WIDTH-1:0] insm_addr,
  output logic                  writeEn_frBus,
  output logic                  writeEn_frDM,
  output logic                  writeEn_frInsM,
  output logic                  ack_bus,
  output logic                  ack_dm,
  output logic                  ack_insm,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  src_vec_t         gnt_q;
  src_vec_t         req_vec;
  src_vec_t         pick;
  logic             wr_go;

  assign req_vec = {req_insm, req_dm, req_bus};

`ifdef DR_ARB_RR_EN
  src_idx_t ptr;

  dr_arb_pick u_pick (
    .ptr (ptr),
    .req (req_vec),
    .gnt (pick)
  );
`else
  dr_arb_pick u_pick (
    .req (req_vec),
    .gnt (pick)
  );
`endif

  // Outputs are registered, so the memory write is launched on the edge
  // that enters WR: from RD when MEM_LAT==1, else from the last WAIT cycle.
  assign wr_go = ((state == ST_RD) && (MEM_LAT == 1)) ||
                 ((state == ST_WAIT) && (cnt == CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      gnt_q          <= '0;
      dm_rd          <= 1'b0;
      dm_addr        <= '0;
      insm_rd        <= 1'b0;
      insm_addr      <= '0;
      writeEn_frBus  <= 1'b0;
      writeEn_frDM   <= 1'b0;
      writeEn_frInsM <= 1'b0;
      ack_bus        <= 1'b0;
      ack_dm         <= 1'b0;
      ack_insm       <= 1'b0;
      busy           <= 1'b0;
`ifdef DR_ARB_RR_EN
      ptr            <= src_idx_t'(SRC_BUS);
`endif
    end else begin
      dm_rd          <= 1'b0;
      insm_rd        <= 1'b0;
      writeEn_frBus  <= 1'b0;
      writeEn_frDM   <= 1'b0;
      writeEn_frInsM <= 1'b0;
      ack_bus        <= 1'b0;
      ack_dm         <= 1'b0;
      ack_insm       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (|req_vec) begin
            gnt_q <= pick;
            busy  <= 1'b1;
            if (pick[SRC_BUS]) begin
              state         <= ST_WR;
              writeEn_frBus <= 1'b1;
              ack_bus       <= 1'b1;
            end else begin
              state <= ST_RD;
              if (pick[SRC_DM]) begin
                dm_rd   <= 1'b1;
                dm_addr <= dm_addr_in;
              end else begin
                insm_rd   <= 1'b1;
                insm_addr <= insm_addr_in;
              end
            end
          end
        end
        ST_RD: begin
          cnt   <= CNT_LOAD;
          state <= (MEM_LAT > 1) ? ST_WAIT : ST_WR;
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= ST_WR;
        end
        ST_WR: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
`ifdef DR_ARB_RR_EN
          ptr   <= next_src(onehot_to_idx(gnt_q));
`endif
        end
        default: state <= ST_IDLE;
      endcase

      if (wr_go) begin
        writeEn_frDM   <= gnt_q[SRC_DM];
        ack_dm         <= gnt_q[SRC_DM];
        writeEn_frInsM <= gnt_q[SRC_INSM];
        ack_insm       <= gnt_q[SRC_INSM];
      end
    end
  end

endmodule

// File: tb/tb_dr_load_arbiter.sv
// Directed self-checking bench for dr_load_arbiter (MEM_LAT=2 and MEM_LAT=4 instances).
module tb_dr_load_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_bus, req_dm, req_insm;
  logic [11:0] dm_addr_in, insm_addr_in;
  logic        dm_rd, insm_rd;
  logic [11:0] dm_addr, insm_addr;
  logic        writeEn_frBus, writeEn_frDM, writeEn_frInsM;
  logic        ack_bus, ack_dm, ack_insm, busy;

  logic        req_insm4;
  logic [11:0] insm_addr4_in;
  logic        dm_rd4, insm_rd4;
  logic [11:0] dm_addr4, insm_addr4;
  logic        we_bus4, we_dm4, we_insm4;
  logic        ack_bus4, ack_dm4, ack_insm4, busy4;

  logic [2:0] we, acks, we4, acks4;
  assign we    = {writeEn_frInsM, writeEn_frDM, writeEn_frBus};
  assign acks  = {ack_insm, ack_dm, ack_bus};
  assign we4   = {we_insm4, we_dm4, we_bus4};
  assign acks4 = {ack_insm4, ack_dm4, ack_bus4};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dr_load_arbiter #(.ADDR_WIDTH(12), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .req_bus(req_bus), .req_dm(req_dm), .req_insm(req_insm),
    .dm_addr_in(dm_addr_in), .insm_addr_in(insm_addr_in),
    .dm_rd(dm_rd), .dm_addr(dm_addr), .insm_rd(insm_rd), .insm_addr(insm_addr),
    .writeEn_frBus(writeEn_frBus), .writeEn_frDM(writeEn_frDM), .writeEn_frInsM(writeEn_frInsM),
    .ack_bus(ack_bus), .ack_dm(ack_dm), .ack_insm(ack_insm), .busy(busy)
  );

  dr_load_arbiter #(.ADDR_WIDTH(12), .MEM_LAT(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_bus(1'b0), .req_dm(1'b0), .req_insm(req_insm4),
    .dm_addr_in(12'h000), .insm_addr_in(insm_addr4_in),
    .dm_rd(dm_rd4), .dm_addr(dm_addr4), .insm_rd(insm_rd4), .insm_addr(insm_addr4),
    .writeEn_frBus(we_bus4), .writeEn_frDM(we_dm4), .writeEn_frInsM(we_insm4),
    .ack_bus(ack_bus4), .ack_dm(ack_dm4), .ack_insm(ack_insm4), .busy(busy4)
  );

  task automatic drain(input string tag);
    req_bus = 0; req_dm = 0; req_insm = 0; req_insm4 = 0;
    for (int i = 0; i < 20 && (busy || busy4); i++) @(negedge clk);
    n_checks++;
    if (busy || busy4) begin
      n_fail++;
      $display("FAIL %s_drain: busy=%b busy4=%b, required 0/0", tag, busy, busy4);
    end
  endtask

  task automatic pulse_reset;
    reset = 1; @(negedge clk); reset = 0;
  endtask

  task automatic test_reset;
    logic seen_ack;
    reset = 1; req_bus = 1; req_dm = 1; req_insm = 1; req_insm4 = 1;
    dm_addr_in = 12'h111; insm_addr_in = 12'h2A5; insm_addr4_in = 12'h0F0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({dm_rd, insm_rd, we, acks, dm_addr, insm_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd=%b%b we=%b ack=%b dm_addr=%h insm_addr=%h, required all 0",
               dm_rd, insm_rd, we, acks, dm_addr, insm_addr);
    end
    n_checks++;
    if (busy !== 1'b0 || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: busy=%b busy4=%b, required 0", busy, busy4);
    end
    reset = 0;
    @(negedge clk);
`ifdef DR_ARB_RR_EN
    n_checks++;
    if (we !== 3'b001 || insm_rd !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_grant: we=%b insm_rd=%b, required we=001", we, insm_rd);
    end
    drain("reset");
`else
    n_checks++;
    if (insm_rd !== 1'b1 || insm_addr !== 12'h2A5 || dm_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_grant: insm_rd=%b insm_addr=%h dm_rd=%b, required 1/2a5/0",
               insm_rd, insm_addr, dm_rd);
    end
    // request withdrawn after grant must still complete
    req_bus = 0; req_dm = 0; req_insm = 0; req_insm4 = 0;
    seen_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack_insm && writeEn_frInsM) seen_ack = 1'b1;
    end
    n_checks++;
    if (seen_ack !== 1'b1) begin
      n_fail++; $display("FAIL dropped_req_ack: ack seen=%b, required 1", seen_ack);
    end
    drain("reset");
`endif
  endtask

  task automatic test_bus;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bus_pre_busy: busy=%b, required 0", busy); end
    req_bus = 1;
    @(negedge clk);
    n_checks++;
    if (we !== 3'b001 || acks !== 3'b001 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bus_t1: we=%b ack=%b busy=%b, required 001/001/1", we, acks, busy);
    end
    req_bus = 0;
    @(negedge clk);
    n_checks++;
    if (we !== 3'b000 || acks !== 3'b000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bus_t2: we=%b ack=%b busy=%b, required 000/000/0", we, acks, busy);
    end
  endtask

  task automatic test_dm;
    req_dm = 1; dm_addr_in = 12'h083;
    @(negedge clk);
    n_checks++;
    if (dm_rd !== 1'b1 || dm_addr !== 12'h083 || insm_rd !== 1'b0 || we !== 3'b000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL dm_t1: dm_rd=%b dm_addr=%h insm_rd=%b we=%b busy=%b, required 1/083/0/000/1",
               dm_rd, dm_addr, insm_rd, we, busy);
    end
    dm_addr_in = 12'h7FF;
    @(negedge clk);
    n_checks++;
    if (dm_rd !== 1'b0 || we !== 3'b000 || busy !== 1'b1 || dm_addr !== 12'h083) begin
      n_fail++;
      $display("FAIL dm_t2: dm_rd=%b we=%b busy=%b dm_addr=%h, required 0/000/1/083", dm_rd, we, busy, dm_addr);
    end
    @(negedge clk);
    n_checks++;
    if (we !== 3'b010 || acks !== 3'b010 || busy !== 1'b1) begin
      n_fail++; $display("FAIL dm_t3: we=%b ack=%b busy=%b, required 010/010/1", we, acks, busy);
    end
    req_dm = 0;
    @(negedge clk);
    n_checks++;
    if (we !== 3'b000 || acks !== 3'b000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL dm_t4: we=%b ack=%b busy=%b, required 000/000/0", we, acks, busy);
    end
  endtask

  task automatic test_back_to_back;
    req_bus = 1;
    @(negedge clk);
    n_checks++;
    if (we !== 3'b001) begin n_fail++; $display("FAIL b2b_first: we=%b, required 001", we); end
    @(negedge clk);
    n_checks++;
    if (we !== 3'b000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap: we=%b busy=%b, required 000/0", we, busy);
    end
    @(negedge clk);
    n_checks++;
    if (we !== 3'b001 || acks !== 3'b001) begin
      n_fail++; $display("FAIL b2b_second: we=%b ack=%b, required 001/001", we, acks);
    end
    req_bus = 0;
    @(negedge clk);
  endtask

  task automatic run_grants(input int n_grants, input logic drop_on_ack, output int order[6], output int done);
    logic prev_we = 1'b0;
    done = 0;
    for (int c = 0; c < 80 && done < n_grants; c++) begin
      @(negedge clk);
      n_checks++;
      if ((we & (we - 3'd1)) !== 3'b000) begin
        n_fail++; $display("FAIL we_onehot: we=%b, required one-hot or zero", we);
      end
      n_checks++;
      if (dm_rd && insm_rd) begin
        n_fail++; $display("FAIL rd_exclusive: dm_rd=%b insm_rd=%b, required not both", dm_rd, insm_rd);
      end
      n_checks++;
      if (prev_we && (|we)) begin
        n_fail++; $display("FAIL wr_gap: consecutive WR cycles, required an IDLE cycle between");
      end
      prev_we = |we;
      if (|we) begin
        order[done] = we[2] ? 2 : (we[1] ? 1 : 0);
        if (drop_on_ack) begin
          if (we[0]) req_bus = 0;
          if (we[1]) req_dm = 0;
          if (we[2]) req_insm = 0;
        end
        done++;
      end
    end
  endtask

  task automatic test_priority;
    int order[6];
    int done;
    int exp_order[3];
`ifdef DR_ARB_RR_EN
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2;
`else
    exp_order[0] = 2; exp_order[1] = 1; exp_order[2] = 0;
`endif
    pulse_reset();
    dm_addr_in = 12'h0A1; insm_addr_in = 12'h0B2;
    req_bus = 1; req_dm = 1; req_insm = 1;
    run_grants(3, 1'b1, order, done);
    n_checks++;
    if (done != 3) begin
      n_fail++; $display("FAIL priority_count: completions=%0d, required 3", done);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (order[i] != exp_order[i]) begin
          n_fail++; $display("FAIL priority_order[%0d]: src=%0d, required %0d", i, order[i], exp_order[i]);
        end
      end
    end
    drain("priority");
  endtask

`ifdef DR_ARB_RR_EN
  task automatic test_rr;
    int order[6];
    int done;
    pulse_reset();
    req_bus = 1; req_dm = 1; req_insm = 1;
    run_grants(6, 1'b0, order, done);
    n_checks++;
    if (done != 6) begin
      n_fail++; $display("FAIL rr_count: grants=%0d, required 6", done);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (order[i] != (i % 3)) begin
          n_fail++; $display("FAIL rr_order[%0d]: src=%0d, required %0d", i, order[i], i % 3);
        end
      end
    end
    drain("rr");
  endtask
`endif

  task automatic test_reset_mid;
    logic bad;
    req_insm4 = 1; insm_addr4_in = 12'h155;
    @(negedge clk);
    n_checks++;
    if (insm_rd4 !== 1'b1 || insm_addr4 !== 12'h155) begin
      n_fail++; $display("FAIL mid_rd: insm_rd=%b insm_addr=%h, required 1/155", insm_rd4, insm_addr4);
    end
    @(negedge clk);
    n_checks++;
    if (busy4 !== 1'b1 || we4 !== 3'b000) begin
      n_fail++; $display("FAIL mid_wait: busy=%b we=%b, required 1/000", busy4, we4);
    end
    reset = 1; req_insm4 = 0;
    @(negedge clk);
    n_checks++;
    if ({dm_rd4, insm_rd4, we4, acks4, busy4, dm_addr4, insm_addr4} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: rd=%b%b we=%b ack=%b busy=%b insm_addr=%h, required all 0",
               dm_rd4, insm_rd4, we4, acks4, busy4, insm_addr4);
    end
    reset = 0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (we4 !== 3'b000 || acks4 !== 3'b000 || busy4 !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL mid_aborted: write/ack after reset seen=%b, required 0", bad);
    end
    req_insm4 = 1; insm_addr4_in = 12'h3C0;
    @(negedge clk);
    n_checks++;
    if (insm_rd4 !== 1'b1 || insm_addr4 !== 12'h3C0) begin
      n_fail++; $display("FAIL mid_new_rd: insm_rd=%b insm_addr=%h, required 1/3c0", insm_rd4, insm_addr4);
    end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (k < 5) begin
        if (we4 !== 3'b000 || acks4 !== 3'b000) begin
          n_fail++; $display("FAIL mid_new_early[%0d]: we=%b ack=%b, required 000/000", k, we4, acks4);
        end
      end else begin
        if (we4 !== 3'b100 || acks4 !== 3'b100) begin
          n_fail++; $display("FAIL mid_new_wr: we=%b ack=%b, required 100/100", we4, acks4);
        end
        req_insm4 = 0;
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy4 !== 1'b0 || we4 !== 3'b000) begin
      n_fail++; $display("FAIL mid_new_idle: busy=%b we=%b, required 0/000", busy4, we4);
    end
  endtask

  initial begin
    reset = 1; req_bus = 0; req_dm = 0; req_insm = 0; req_insm4 = 0;
    dm_addr_in = '0; insm_addr_in = '0; insm_addr4_in = '0;
    @(negedge clk);
    test_reset();
    test_bus();
    test_dm();
    test_back_to_back();
    test_priority();
`ifdef DR_ARB_RR_EN
    test_rr();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dr_load_arbiter.md
Name: dr_load_arbiter

Overview:
Sequencer and arbiter for the 12-bit data register (DR) load paths. Three requesters compete for DR: the bus, the data memory (DM) and the instruction memory (InsM). The block grants one requester at a time and issues the memory read strobe and address when needed. It waits out the memory read latency, then drives exactly one of the DR write enables for one cycle and acknowledges the requester. It sits between the control unit/bus master and DR plus the two memories.

Parameters:
ADDR_WIDTH, 12, width of DM and InsM addresses
MEM_LAT, 2, cycles from read strobe to valid memory data; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req_bus  input  1  request DR load from bus (data already valid on bus)
req_dm  input  1  request DR load from DM
req_insm  input  1  request DR load from InsM
dm_addr_in  input  ADDR_WIDTH  DM address, sampled at grant
insm_addr_in  input  ADDR_WIDTH  InsM address, sampled at grant
dm_rd  output  1  DM read strobe, one cycle
dm_addr  output  ADDR_WIDTH  registered DM address
insm_rd  output  1  InsM read strobe, one cycle
insm_addr  output  ADDR_WIDTH  registered InsM address
writeEn_frBus  output  1  DR write enable, bus source
writeEn_frDM  output  1  DR write enable, DM source
writeEn_frInsM  output  1  DR write enable, InsM source
ack_bus, ack_dm, ack_insm  output  1 each  one-cycle completion pulses
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Single clock clk; reset is synchronous and active-high.
- Reset:
  - FSM goes to IDLE.
  - All strobes, enables, acks and busy are 0.
  - dm_addr and insm_addr are 0.
  - Wait counter is 0.
  - RR pointer (when compiled in) points at bus.
- Reset mid-operation aborts the transfer: no write enable and no ack are issued.
- All outputs are registered.
- FSM states: IDLE, RD, WAIT, WR.
- IDLE, any req high on cycle t: latch the winner (grant, plus address for DM/InsM) at the end of t.
  - Bus winner: go to WR.
  - DM/InsM winner: go to RD.
- RD, cycle t+1: assert the winner's rd strobe with the registered address.
  - Load the counter with MEM_LAT-1.
  - Go to WAIT if MEM_LAT>1, else go to WR.
- WAIT: decrement the counter each cycle; go to WR when it reaches 0.
- WR: assert exactly one writeEn_frX and the matching ack_X in the same cycle, then go to IDLE.
- Latency:
  - Bus: req at t gives write enable at t+1.
  - DM/InsM: req at t gives write enable at t+1+MEM_LAT.
- Back-to-back requests: at least one IDLE cycle separates consecutive WR cycles. Arbitration happens only in IDLE.
- Handshake:
  - req is level-sensitive and is held until ack.
  - A req dropped after grant does not cancel the transfer; the ack still pulses.
  - A req still high in the cycle after its ack is treated as a new request.
- Simultaneous requests: default fixed priority is InsM > DM > bus. Losers stay pending; no request is lost.
- Invariants:
  - Write enables are one-hot or zero; they are never multi-hot.
  - At most one of dm_rd/insm_rd is high at any time.
- busy is 1 in RD, WAIT and WR.

Optional Feature:
- Macro: DR_ARB_RR_EN.
- When defined: round-robin arbitration over the order bus -> DM -> InsM -> bus.
  - Pointer advances to the requester after the one granted, updated in WR.
  - Pointer resets to bus.
- When undefined: fixed priority InsM > DM > bus, and no pointer register exists.
- Latency and handshake are identical in both builds.

Decomposition:
- Package dr_arb_pkg holds:
  - FSM state encoding constants (IDLE, RD, WAIT, WR, 2-bit).
  - Requester index constants (SRC_BUS=0, SRC_DM=1, SRC_INSM=2).
  - Counter width constant (4).
- One sub-module, dr_arb_pick: combinational winner select.
  - Inputs: 3-bit req vector and pointer.
  - Output: one-hot grant.
  - Contains the fixed/RR logic under DR_ARB_RR_EN.
- Top module holds the FSM, counter, address registers and output registers.

Test Plan:
- Reset held 2 cycles with all reqs high -> every output is 0 and busy is 0. One cycle after release, a grant is taken: insm_rd pulses under default priority.
- req_bus alone at cycle t -> writeEn_frBus=1 and ack_bus=1 at t+1 only. busy=1 only at t+1.
- req_dm with dm_addr_in=12'h083, MEM_LAT=2 -> dm_rd=1 and dm_addr=12'h083 at t+1; writeEn_frDM and ack_dm at t+3; return to IDLE at t+4.
- req_bus, req_dm and req_insm all held high (default build) -> completion order InsM, DM, bus. Enables are never multi-hot, and at least one IDLE cycle separates consecutive WR cycles.
- With DR_ARB_RR_EN, all three reqs held continuously for 6 grants -> grant order bus, DM, InsM, bus, DM, InsM.
- req_insm, then reset asserted during WAIT (MEM_LAT=4) -> no writeEn_frInsM and no ack_insm. State is IDLE and all outputs are 0 the cycle after reset. A new req_insm completes normally after reset is released.
